// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between the MEM stage and off-chip data memory; stalls the pipeline for the whole of a miss.
module dcache_ctrl #(
    parameter int unsigned INDEX_W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned TAG_W  = 27 - INDEX_W;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_ALLOC
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [INDEX_W-1:0] cpu_idx;
    logic [INDEX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0]   cpu_tag;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [2:0]         cpu_word;
    logic [LINE_W-1:0]  cpu_line;
    logic [WORD_W-1:0]  cpu_word_data;
    logic               hit;
    logic               miss;
    logic               store_hit;
    logic               refill;
    logic               latch_miss;
    logic               unused_addr;

    logic               mem_enable_d;
    logic               mem_write_d;
    logic [31:0]        mem_addr_d;
    logic [LINE_W-1:0]  mem_data_d;

    // Address decode and combinational lookup of the indexed line
    assign cpu_idx       = cpu_addr_i[4+INDEX_W:5];
    assign cpu_tag       = cpu_addr_i[31:5+INDEX_W];
    assign cpu_word      = cpu_addr_i[4:2];
    assign cpu_line      = data_q[cpu_idx];
    assign cpu_word_data = cpu_line[{cpu_word, 5'd0} +: WORD_W];
    assign unused_addr   = ^cpu_addr_i[1:0];

    assign hit       = cpu_req_i && (state_q == S_IDLE) && valid_q[cpu_idx]
                       && (tag_q[cpu_idx] == cpu_tag);
    assign miss      = cpu_req_i && !hit;
    assign store_hit = hit && cpu_we_i;
    assign refill    = (state_q == S_ALLOC) && mem_ack_i;

    assign cpu_stall_o = miss;
    assign cpu_data_o  = (hit && !cpu_we_i) ? cpu_word_data : '0;

    // State and registered memory-side outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_o <= mem_enable_d;
            mem_write_o  <= mem_write_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
            if (latch_miss) begin
                miss_idx_q <= cpu_idx;
                miss_tag_q <= cpu_tag;
            end
        end
    end

    // Next state and next memory-request values
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_o;
        mem_write_d  = mem_write_o;
        mem_addr_d   = mem_addr_o;
        mem_data_d   = mem_data_o;
        latch_miss   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    latch_miss   = 1'b1;
                    mem_enable_d = 1'b1;
                    if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                        state_d     = S_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[cpu_idx], cpu_idx, 5'b0};
                        mem_data_d  = data_q[cpu_idx];
                    end else begin
                        state_d     = S_ALLOC;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {cpu_tag, cpu_idx, 5'b0};
                        mem_data_d  = '0;
                    end
                end
            end
            S_WB: begin
                if (mem_ack_i) begin
                    state_d      = S_ALLOC;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {miss_tag_q, miss_idx_q, 5'b0};
                    mem_data_d   = '0;
                end
            end
            S_ALLOC: begin
                if (mem_ack_i) begin
                    state_d      = S_IDLE;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = '0;
                    mem_data_d   = '0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
                mem_addr_d   = '0;
                mem_data_d   = '0;
            end
        endcase
    end

    // Line status bits; reset invalidates the whole cache
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (store_hit) begin
            dirty_q[cpu_idx] <= 1'b1;
        end else if (refill) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid_q
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            data_q[cpu_idx][{cpu_word, 5'd0} +: WORD_W] <= cpu_data_i;
        end else if (refill) begin
            data_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the MEM pipeline stage and the off-chip data memory. It serves CPU loads and stores from an internal line array. It raises `cpu_stall_o`, the memory-stall signal that freezes PC, IF_ID and the other pipeline registers, for the full duration of any miss. It runs the line write-back and refill handshakes toward data memory.

## Interface
Parameters:
- `INDEX_W`, default 4: index bits. The cache has 2^INDEX_W lines of 256 bits (32 B, 8 words). Tag is address[31:5+INDEX_W].

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `cpu_req_i`, in, 1: CPU access valid this cycle.
- `cpu_we_i`, in, 1: 1 = store, 0 = load.
- `cpu_addr_i`, in, 32: byte address. Bits [1:0] are ignored, [4:2] select the word, [4+INDEX_W:5] select the index.
- `cpu_data_i`, in, 32: store data.
- `cpu_data_o`, out, 32: load data, valid when `cpu_req_i` is 1 and `cpu_stall_o` is 0.
- `cpu_stall_o`, out, 1: pipeline must hold.
- `mem_enable_o`, out, 1: memory request.
- `mem_write_o`, out, 1: 1 = line write, 0 = line read.
- `mem_addr_o`, out, 32: line-aligned address, bits [4:0] = 0.
- `mem_data_o`, out, 256: write-back line.
- `mem_data_i`, in, 256: refill line, valid in the `mem_ack_i` cycle.
- `mem_ack_i`, in, 1: one-cycle completion pulse from memory.

## Operation
Per-line storage: valid bit, dirty bit, tag, 256-bit data. The storage is flop-based and readable combinationally.

A hit requires `cpu_req_i` = 1, the state is IDLE, the indexed line is valid, and its tag equals the address tag.

- **Load hit:** `cpu_data_o` = selected word, `cpu_stall_o` = 0.
- **Store hit:** `cpu_stall_o` = 0. At the next edge the selected word is written and the dirty bit is set.
- **Miss** (`cpu_req_i` = 1 and not hit, in any state): `cpu_stall_o` = 1 combinationally.
- **`cpu_req_i` = 0:** `cpu_stall_o` = 0, `cpu_data_o` = 0, and no state change.
- **`cpu_data_o` when not a load hit:** 0.

FSM states are IDLE, WB and ALLOC.
- **IDLE to WB:** on a miss where the victim line is valid and dirty.
- **IDLE to ALLOC:** on a miss where the victim line is clean or invalid.
- **WB:** `mem_enable_o` = 1, `mem_write_o` = 1, `mem_addr_o` = {victim tag, index, 5'b0}, `mem_data_o` = victim line. These hold until `mem_ack_i` is seen. On the ack edge the FSM goes to ALLOC.
- **ALLOC:** `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = {CPU tag, index, 5'b0}. These hold until `mem_ack_i` is seen. On the ack edge the line is loaded from `mem_data_i`, valid is set, dirty is cleared, the tag is written, and the FSM returns to IDLE.
- **After refill:** in IDLE the held request now hits and completes normally. A store miss is therefore merged on that hit cycle.

Other rules:
- In IDLE, `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are all 0.
- A `mem_ack_i` received in IDLE is ignored.
- The CPU inputs are held stable by the pipeline while `cpu_stall_o` = 1. The controller latches the miss address at IDLE exit and uses the latched value for `mem_addr_o`.

## Timing
Reset values (asynchronous, while `rst_i` = 0):
- State is IDLE.
- All valid and dirty bits are 0. Tags and data are don't-care.
- `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o` and `cpu_data_o` are 0.
- `cpu_stall_o` is 0 while `cpu_req_i` = 0.

Latency:
- **Hit:** 0 extra cycles.
- **Clean miss:** the miss is detected in cycle 0. `mem_enable_o` rises in cycle 1. If the ack arrives in cycle N, the hit and stall release occur in cycle N+1.
- **Dirty miss:** adds the write-back phase. ALLOC begins the cycle after the WB ack.
- Memory outputs are registered state decodes and drop the cycle after ack.

Reset mid-operation:
- `mem_enable_o` falls immediately (asynchronously).
- The pending transaction is abandoned.
- All lines become invalid, so the next access misses.

## Test plan
- **Cold load miss:** reset, then load 0x40. Expect `cpu_stall_o` = 1, and in cycle 1 `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = 0x40. Ack in cycle 10 with word 2 = 0xDEADBEEF. Expect no stall in cycle 11, and a load of 0x48 returns 0xDEADBEEF.
- **Store hit:** store 0x12345678 to 0x44 after the refill above. Expect no stall and no memory activity. The next load of 0x44 returns 0x12345678, and line 2 is dirty.
- **Dirty conflict:** load 0x240 (index 2). Expect WB with `mem_addr_o` = 0x40 and `mem_data_o` word 1 = 0x12345678. After the ack expect ALLOC with `mem_addr_o` = 0x240. After the second ack, the load of 0x240 hits.
- **Store miss:** store 0xA5A5A5A5 to 0x80 on an invalid line. Expect ALLOC of 0x80, then the store merges in the hit cycle. Line 4 is dirty and a load of 0x80 returns 0xA5A5A5A5.
- **Reset during ALLOC:** assert `rst_i` = 0 mid-wait. Expect `mem_enable_o` = 0 the same cycle. After release, a load of 0x40 misses again.
- **Idle/spurious:** with `cpu_req_i` = 0 for 20 cycles and a stray `mem_ack_i` pulse, expect stall 0, no `mem_enable_o`, and the cache contents unchanged.
